// File: rtl/hit_scan_enc.sv
// Sequential multi-hit priority encoder: reports every set bit of an accepted hit vector, lowest index first.
// Optional popcount output enabled by defining HIT_SCAN_COUNT_EN.
module hit_scan_enc #(
  parameter int SIZE = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2**SIZE-1:0]   in_hits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0]      out_idx,
  output logic                 out_last,
  output logic                 busy
`ifdef HIT_SCAN_COUNT_EN
  ,
  output logic [SIZE:0]        out_count
`endif
);

  localparam int N = 2**SIZE;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    pending_reg, pending_next;
  logic [N-1:0]    pending_less;
  logic [N-1:0]    pending_cleared;
  logic [N-1:0]    lowest_onehot;
  logic            beat;
  logic            accept;
  logic            load_hits;

  // pending-1 flips the lowest set bit and everything below it, which yields
  // both the isolated lowest bit and the vector with that bit removed.
  assign pending_less    = pending_reg - N'(1);
  assign pending_cleared = pending_reg & pending_less;
  assign lowest_onehot   = pending_reg & ~pending_less;

  assign out_valid = (state_reg == SCAN);
  assign busy      = (state_reg == SCAN);
  assign out_last  = (pending_reg != '0) && (pending_cleared == '0);

  assign beat      = out_valid && out_ready;
  assign in_ready  = (state_reg == IDLE) || (beat && out_last);
  assign accept    = in_valid && in_ready;
  assign load_hits = accept && (in_hits != '0);

  // One-hot to binary: index bit gi is the OR of all one-hot positions whose index has bit gi set.
  genvar gi, gj;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_enc_bit
      logic [N-1:0] bit_mask;
      for (gj = 0; gj < N; gj++) begin : g_mask
        assign bit_mask[gj] = 1'(gj >> gi);
      end
      assign out_idx[gi] = |(lowest_onehot & bit_mask);
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    case (state_reg)
      IDLE: begin
        if (load_hits) begin
          pending_next = in_hits;
          state_next   = SCAN;
        end
      end
      SCAN: begin
        if (beat) begin
          if (!out_last) begin
            pending_next = pending_cleared;
          end else if (load_hits) begin
            pending_next = in_hits;
          end else begin
            pending_next = '0;
            state_next   = IDLE;
          end
        end
      end
      default: begin
        pending_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

`ifdef HIT_SCAN_COUNT_EN
  logic [SIZE:0] count_reg;
  logic [SIZE:0] count_next;

  always_comb begin
    count_next = '0;
    for (int i = 0; i < N; i++) begin
      count_next = count_next + (SIZE+1)'(in_hits[i]);
    end
  end

  // Latched only when a vector actually starts a scan, so it stays valid for every beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load_hits) begin
      count_reg <= count_next;
    end
  end

  assign out_count = count_reg;
`endif

endmodule
